uart_rx_frontend: RTL

Serial receive front-end that sits directly upstream of the UART controller's byte buffer. It synchronises the asynchronous rx pin, times bit periods with a per-bit clock-cycle counter, majority-votes each bit, and deframes start + 8 data (LSB first) + even parity + stop. Each completed byte is offered on a valid/ready handshake, with parity, framing and overrun status, so the controller only ever pushes checked bytes.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_sampler.sv | 70 +++++++
 rtl/uart_rx_frontend.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame geometry and parity mode.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } parity_mode_t;

    localparam parity_mode_t PARITY_MODE = EVEN;

endpackage

// File: rtl/uart_bit_sampler.sv
// rx synchroniser, per-bit cycle counter and 3-sample majority vote.
module uart_bit_sampler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic rx,
    input  logic restart,
    output logic rx_s,
    output logic vote_strobe,
    output logic vote,
    output logic wrap_strobe
);

    localparam int MID = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_SAMP_A = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_SAMP_B = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_VOTE   = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             samp_a;
    logic             samp_b;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= rx;
            sync_p1 <= sync_p0;
        end
    end

    // Bit-period counter, held at zero while the FSM requests a restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Capture the first two of the three mid-bit samples; the third is live rx_s.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (cnt == CNT_SAMP_A) samp_a <= sync_p1;
            if (cnt == CNT_SAMP_B) samp_b <= sync_p1;
        end
    end

    assign rx_s        = sync_p1;
    assign vote_strobe = (cnt == CNT_VOTE);
    assign wrap_strobe = (cnt == CNT_LAST);
    assign vote        = majority3(samp_a, samp_b, sync_p1);

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front-end: deframes start/8 data/parity/stop and offers checked
// bytes on a valid/ready handshake with parity, framing and overrun status.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       out_ready,
    input  logic       clear_status,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    rx_state_t  state;
    logic       rx_s;
    logic       vote_strobe;
    logic       vote;
    logic       wrap_strobe;
    logic       restart;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;
    logic       par_acc;
    logic       par_bad;
    logic       frame_done;

    assign restart    = (state == IDLE);
    assign frame_done = (state == STOP) && vote_strobe;

    uart_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_sampler (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .restart     (restart),
        .rx_s        (rx_s),
        .vote_strobe (vote_strobe),
        .vote        (vote),
        .wrap_strobe (wrap_strobe)
    );

    // Frame FSM plus the output holding register and sticky overrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            par_acc     <= 1'b0;
            par_bad     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    // A start bit that votes high was a glitch on an idle line.
                    if (vote_strobe && vote) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wrap_strobe) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        par_acc <= 1'b0;
                    end
                end
                DATA: begin
                    if (vote_strobe) begin
                        shift_reg[bit_idx] <= vote;
                        par_acc            <= par_acc ^ vote;
                    end
                    if (wrap_strobe) begin
                        if (bit_idx == LAST_BIT) state <= PARITY;
                        else bit_idx <= bit_idx + 1'b1;
                    end
                end
                PARITY: begin
                    if (vote_strobe) par_bad <= vote ^ par_acc ^ (PARITY_MODE == ODD);
                    if (wrap_strobe) state <= STOP;
                end
                STOP: begin
                    // Leave at the stop vote so a back-to-back start edge is not missed.
                    if (vote_strobe) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (frame_done && (!out_valid || out_ready)) begin
                out_valid  <= 1'b1;
                out_data   <= shift_reg;
                parity_err <= par_bad;
                frame_err  <= !vote;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Overrun is written last so a coincident drop beats clear_status.
            if (clear_status) overrun_err <= 1'b0;
            if (frame_done && out_valid && !out_ready) overrun_err <= 1'b1;
        end
    end

endmodule
